// File: rtl/isqrt_iterative.sv
// ----------------------------------------------------------------------------
// isqrt_iterative
//   Iterative restoring integer square root. One root bit is resolved per
//   clock, so a 2*NUMBITS-bit radicand finishes in NUMBITS cycles. Produces
//   floor(sqrt(x)) and the remainder x - root^2.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   radicand on in_data is valid
//   in_ready   block can accept a radicand (high only in IDLE)
//   in_data    radicand x, unsigned, 2*NUMBITS bits
//   out_valid  out_root/out_rem hold a finished result
//   out_ready  consumer accepts the result
//   out_root   floor(sqrt(x)), NUMBITS bits
//   out_rem    x - out_root^2, NUMBITS+1 bits (never exceeds 2*out_root)
//   busy       high while calculating or holding a result
// ----------------------------------------------------------------------------
module isqrt_iterative #(
    parameter int NUMBITS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*NUMBITS-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUMBITS-1:0]     out_root,
    output logic [NUMBITS:0]       out_rem,
    output logic                   busy
);

    localparam int CW = (NUMBITS > 1) ? $clog2(NUMBITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                 state;
    logic [2*NUMBITS-1:0]   shreg;   // radicand, consumed two bits per step from the top
    logic [NUMBITS+1:0]     rem;     // partial remainder
    logic [NUMBITS-1:0]     root;    // partial root
    logic [CW-1:0]          cnt;     // steps remaining after the current one

    // One restoring step, evaluated from the current registers.
    // The remainder never exceeds 2*root, so before the shift-in its value fits
    // in NUMBITS bits; the trial value is formed wide so every register bit
    // takes part in the compare and subtract.
    logic [NUMBITS+3:0]     r_wide;
    logic [NUMBITS+3:0]     t_wide;
    logic                   ge;
    logic [NUMBITS+1:0]     rem_next;
    logic [NUMBITS-1:0]     root_next;

    // NOTE: every always_comb output is assigned on every path through the
    // block, so no storage (latch) can be inferred.
    always_comb begin
        r_wide    = {rem, shreg[2*NUMBITS-1 -: 2]};
        t_wide    = {2'b00, root, 2'b01};
        ge        = (r_wide >= t_wide);
        rem_next  = ge ? (NUMBITS+2)'(r_wide - t_wide) : r_wide[NUMBITS+1:0];
        root_next = {root[NUMBITS-2:0], ge};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears the datapath registers as well
        // as the control state, so an aborted calculation leaves nothing behind.
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_root  <= '0;
            out_rem   <= '0;
            busy      <= 1'b0;
            shreg     <= '0;
            rem       <= '0;
            root      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone accepts.
                    if (in_valid) begin
                        shreg    <= in_data;
                        rem      <= '0;
                        root     <= '0;
                        cnt      <= CW'(NUMBITS - 1);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end

                CALC: begin
                    shreg <= {shreg[2*NUMBITS-3:0], 2'b00};
                    rem   <= rem_next;
                    root  <= root_next;
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0) begin
                        // Final step: publish the result straight from the step logic.
                        out_root  <= root_next;
                        out_rem   <= rem_next[NUMBITS:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    // out_root/out_rem are left as-is on the way back to IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_iterative.sv
module tb_isqrt_iterative;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_root;
    logic [32:0] out_rem;
    logic        busy;

    logic        d8_in_valid;
    logic        d8_in_ready;
    logic [15:0] d8_in_data;
    logic        d8_out_valid;
    logic        d8_out_ready;
    logic [7:0]  d8_out_root;
    logic [8:0]  d8_out_rem;
    logic        d8_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    isqrt_iterative #(.NUMBITS(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root),
        .out_rem   (out_rem),
        .busy      (busy)
    );

    isqrt_iterative #(.NUMBITS(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d8_in_valid),
        .in_ready  (d8_in_ready),
        .in_data   (d8_in_data),
        .out_valid (d8_out_valid),
        .out_ready (d8_out_ready),
        .out_root  (d8_out_root),
        .out_rem   (d8_out_rem),
        .busy      (d8_busy)
    );

    // Reference: largest r with r*r <= x, found by binary search over the
    // root range, remainder by direct subtraction.
    function automatic void isqrt_ref(input logic [63:0] x, input int nb,
                                      output logic [63:0] root, output logic [63:0] rem);
        logic [63:0] lo, hi, mid;
        lo = 64'd0;
        hi = (64'd1 << nb) - 64'd1;
        while (lo < hi) begin
            mid = lo + (hi - lo + 64'd1) / 64'd2;
            if (mid * mid <= x) lo = mid;
            else                hi = mid - 64'd1;
        end
        root = lo;
        rem  = x - lo * lo;
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the 32-bit instance; optionally hold out_ready low
    // for 'hold' cycles with a competing in_valid asserted.
    task automatic txn32(input logic [63:0] x, input int hold);
        logic [63:0] er, em;
        int          cyc;
        isqrt_ref(x, 32, er, em);
        in_data  = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        check("calc_in_ready", 64'(in_ready), 64'd0);
        check("calc_busy", 64'(busy), 64'd1);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("latency", 64'(cyc), 64'd32);
        check("root", 64'(out_root), er);
        check("rem", 64'(out_rem), em);
        check("squarer_sum", 64'(out_root) * 64'(out_root) + 64'(out_rem), x);
        check("rem_bound", 64'(64'(out_rem) <= 64'd2 * 64'(out_root)), 64'd1);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 64'd5;
            tick();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_root", 64'(out_root), er);
            check("hold_rem", 64'(out_rem), em);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic txn8(input logic [15:0] x);
        logic [63:0] er, em;
        int          cyc;
        isqrt_ref(64'(x), 8, er, em);
        d8_in_data  = x;
        d8_in_valid = 1'b1;
        tick();
        d8_in_valid = 1'b0;
        cyc = 0;
        while (!d8_out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("n8_latency", 64'(cyc), 64'd8);
        check("n8_root", 64'(d8_out_root), er);
        check("n8_rem", 64'(d8_out_rem), em);
        d8_out_ready = 1'b1;
        tick();
        d8_out_ready = 1'b0;
        check("n8_idle", 64'(d8_in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] x, r;
        logic [63:0] exp_root[2];
        logic [63:0] exp_rem[2];
        int          acc_cyc[2];
        int          n_acc, n_res;
        logic        acc_now;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        d8_in_valid  = 1'b0;
        d8_in_data   = '0;
        d8_out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_root", 64'(out_root), 64'd0);
        check("rst_rem", 64'(out_rem), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Directed boundary radicands
        txn32(64'd0, 0);
        txn32(64'hFFFF_FFFF_FFFF_FFFF, 0);
        check("max_root_const", 64'(out_root), 64'hFFFF_FFFF);
        check("max_rem_const", 64'(out_rem), 64'h1_FFFF_FFFE);
        txn32(64'd99, 0);
        check("x99_root_const", 64'(out_root), 64'd9);
        check("x99_rem_const", 64'(out_rem), 64'd18);
        txn32(64'd1 << 62, 0);

        // Backpressure: out_ready low for 10 cycles, competing in_valid ignored
        txn32(64'd1_000_000_007, 10);

        // Reset in the middle of a calculation
        in_data  = 64'h1234_5678_9ABC_DEF0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (11) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_root", 64'(out_root), 64'd0);
        check("midrst_rem", 64'(out_rem), 64'd0);
        repeat (40) tick();
        check("midrst_no_result", 64'(out_valid), 64'd0);
        txn32(64'd144, 0);

        // Back-to-back with in_valid and out_ready held high
        isqrt_ref(64'd16, 32, exp_root[0], exp_rem[0]);
        isqrt_ref(64'd17, 32, exp_root[1], exp_rem[1]);
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        n_acc      = 0;
        n_res      = 0;
        in_data    = 64'd16;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        for (int c = 0; c < 200 && n_res < 2; c++) begin
            acc_now = in_ready;
            tick();
            if (acc_now && n_acc < 2) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                in_data = 64'd17;
            end
            if (out_valid) begin
                check("b2b_root", 64'(out_root), exp_root[n_res]);
                check("b2b_rem", 64'(out_rem), exp_rem[n_res]);
                n_res++;
            end
        end
        in_valid  = 1'b0;
        check("b2b_results", 64'(n_res), 64'd2);
        check("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd34);
        tick();
        out_ready = 1'b0;
        tick();
        check("b2b_idle", 64'(in_ready), 64'd1);

        // Random radicands, biased toward perfect squares and their neighbours
        for (int i = 0; i < 300; i++) begin
            r = 64'($urandom);
            case ($urandom_range(0, 3))
                0:       x = {$urandom, $urandom};
                1:       x = r * r;
                2:       x = r * r - 64'd1;
                default: x = 64'($urandom_range(0, 1000));
            endcase
            txn32(x, 0);
        end

        // NUMBITS=8 instance: edges plus random
        txn8(16'd0);
        txn8(16'hFFFF);
        txn8(16'd255);
        txn8(16'd256);
        for (int i = 0; i < 200; i++) begin
            txn8(16'($urandom_range(0, 65535)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
